// File: rtl/serial_tx7.sv
// serial_tx7: framed serial transmitter for 7-bit parallel words.
// A word is accepted over a load/ready handshake and shifted out as
// start bit (0), 7 data bits LSB first, optional even-parity bit, stop bit (1).
// Optional feature macro: SERIAL_TX7_PARITY_EN (inserts the parity bit).
// tx, ready and busy are registered; reset is asynchronous, active-high.
module serial_tx7 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] din,
  input  logic       load,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  // Baud counter needs at least one bit even when CLKS_PER_BIT is 1.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

`ifdef SERIAL_TX7_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

  state_t           r_state;
  logic [6:0]       r_shiftReg;
  logic [2:0]       r_bitIdx;
  logic [CNT_W-1:0] r_baudCnt;
  logic             r_tx;
  logic             r_ready;
  logic             r_busy;
`ifdef SERIAL_TX7_PARITY_EN
  logic             r_parityAcc;
`endif

  logic w_bitDone;

  // A serial bit ends on the edge where the baud counter hits its last value.
  assign w_bitDone = (r_baudCnt == LAST_CNT);

  assign tx    = r_tx;
  assign ready = r_ready;
  assign busy  = r_busy;

  // Frame sequencer: each branch sets the line value the next bit will show.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shiftReg <= '0;
      r_bitIdx   <= '0;
      r_baudCnt  <= '0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
`ifdef SERIAL_TX7_PARITY_EN
      r_parityAcc <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_shiftReg <= din;
            r_bitIdx   <= '0;
            r_baudCnt  <= '0;
            r_state    <= START;
            r_tx       <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
`ifdef SERIAL_TX7_PARITY_EN
            r_parityAcc <= ^din;
`endif
          end
        end

        START: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_state   <= DATA;
            r_tx      <= r_shiftReg[0];
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end

        DATA: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            if (r_bitIdx == 3'd6) begin
`ifdef SERIAL_TX7_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_parityAcc;
`else
              r_state <= STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_shiftReg <= r_shiftReg >> 1;
              r_bitIdx   <= r_bitIdx + 3'd1;
              r_tx       <= r_shiftReg[1];
            end
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end

`ifdef SERIAL_TX7_PARITY_EN
        PARITY: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            r_state   <= STOP;
            r_tx      <= 1'b1;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_baudCnt <= '0;
          r_bitIdx  <= '0;
          r_tx      <= 1'b1;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
